truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
Hardware sweep controller for small combinational circuits under test (CUT).
- Drives every input combination onto the CUT inputs in ascending binary order and holds each one for a fixed dwell time.
- Samples the single CUT output on the last dwell cycle and compares it against an expected truth table.
- Reports pass/fail, a mismatch count and the index of the first failing vector.
- Replaces hand-written stimulus sequences in circuit benches and can also run as on-chip self-test.

Parameters:
- N_IN, 3, number of CUT inputs; vector count NV = 2**N_IN.
- DWELL, 20, clock cycles each vector is held; legal minimum 2.
- EXPECTED, 8'hEA, NV-bit expected output; bit i is the expected CUT output for vector i.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled in IDLE or DONE.
- abort  in  1  cancel a sweep; has priority over start.
- stim  out  N_IN  CUT input vector; MSB = A, LSB = last input.
- d_in  in  1  CUT output.
- busy  out  1  high while a sweep is running.
- done  out  1  high in DONE until the next start or abort.
- pass  out  1  valid when done is high; 1 = no mismatches.
- fail_count  out  N_IN+1  number of mismatching vectors.
- first_fail_idx  out  N_IN  index of the first mismatching vector.
- first_fail_valid  out  1  at least one mismatch has been recorded.
- captured  out  NV  sampled CUT output per vector; bit i = vector i.

Behaviour:
- Reset (asynchronous, any state): state = IDLE and every output = 0 immediately, with no clock edge required.
- Exactly one clock; rst_n is asynchronous and active-low. Release of rst_n is synchronised by the integrator.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0 at edge k → RUN at edge k.
  - At the same edge: idx=0, dwell_cnt=0, stim=0, and fail_count, first_fail_*, captured and pass all cleared.
- RUN:
  - stim = idx; busy = 1; dwell_cnt increments every cycle.
  - When dwell_cnt == DWELL-1:
    - captured[idx] ← d_in.
    - On mismatch with EXPECTED[idx]: fail_count += 1. If first_fail_valid = 0, then first_fail_idx ← idx and first_fail_valid ← 1.
    - If idx == NV-1: go to DONE. Otherwise idx += 1 and dwell_cnt ← 0.
  - Latency: vector i is sampled at edge k + DWELL*(i+1); done rises at edge k + NV*DWELL (160 for the defaults).
  - The pass/fail of the final vector is included in the outputs on the same edge that done rises.
  - d_in is sampled only on the last dwell cycle; changes earlier in the dwell are ignored.
  - start while in RUN is ignored.
- DONE:
  - done = 1; busy = 0; stim = 0; pass = (fail_count == 0).
  - start (without abort) → RUN, with results cleared exactly as from IDLE.
- abort (any state except IDLE):
  - Next state IDLE, busy = 0, done = 0, stim = 0.
  - Partial result registers hold their values; pass is forced to 0.
- abort and start together: abort wins and the FSM goes to or stays in IDLE.
- Width: fail_count is N_IN+1 bits so it can hold NV without wrapping. idx never exceeds NV-1 and does not wrap.

Decomposition:
- Shared package truth_table_pkg holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a constant function for NV;
  - the DWELL minimum check constant.
- One sub-module, dwell_timer: a load/enable counter that outputs a terminal pulse when the count equals DWELL-1.
- The sequencer instantiates dwell_timer and owns the FSM and the result registers.

Test Plan:
1. Good CUT model D=(A&B)|C, DWELL=20, start pulse at edge 0 → stim steps 0..7 with one step every 20 cycles; done=1 at edge 160; pass=1; fail_count=0; captured=8'hEA; first_fail_valid=0.
2. CUT stuck-at-0 → done at edge 160; pass=0; fail_count=5; first_fail_idx=1; captured=8'h00.
3. rst_n pulled low at cycle 75 of a sweep → all outputs 0 asynchronously; after release, state is IDLE and nothing happens until start.
4. abort at cycle 50 (during vector 2) → next edge busy=0, stim=0, done=0; vectors 0 and 1 are retained in captured; a later start clears the results and the full sweep completes at 160 cycles after that start.
5. start and abort asserted together in IDLE → no transition. start pulsed again at cycle 30 of a running sweep → ignored, and done still rises at edge 160.
6. d_in glitch on cycle 5 of vector 3 and correct on cycle 19 → no mismatch recorded. Then start from DONE → results cleared and the sweep repeats identically.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared definitions for the truth-table sweep controller: FSM state encoding,
// vector-count helper and the smallest usable dwell time.
package truth_table_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] RUN_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        RUN  = RUN_ENC,
        DONE = DONE_ENC
    } state_t;

    // One sample is taken on the last dwell cycle and the next vector loads
    // on the following one, so a dwell needs at least two cycles.
    localparam int unsigned DWELL_MIN = 2;

    // Number of input combinations for a CUT with n_in inputs.
    function automatic int unsigned nv(input int unsigned n_in);
        return 32'(1) << n_in;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-vector dwell counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the count at zero (wins over en)
//   en         : advance the count by one
//   term_c     : combinational, high while the count equals DWELL-1
module dwell_timer #(
    parameter int unsigned DWELL = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic term_c
);

    localparam int unsigned CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;

    logic [CNT_W-1:0] cnt;

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term_c = (cnt == CNT_W'(DWELL - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input combination of a small combinational CUT in ascending
// order, holds each for DWELL cycles, samples the CUT output on the last dwell
// cycle and checks it against EXPECTED.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : begin / cancel a sweep (abort wins)
//   stim              : CUT input vector, MSB = A
//   d_in              : CUT output
//   busy, done, pass  : sweep status; pass valid while done
//   fail_count        : number of mismatching vectors
//   first_fail_idx/_valid : first mismatching vector
//   captured          : sampled CUT output, bit i = vector i
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int unsigned          N_IN     = 3,
    parameter int unsigned          DWELL    = 20,
    parameter logic [nv(N_IN)-1:0]  EXPECTED = 8'hEA
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [N_IN-1:0]     stim,
    input  logic                d_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       fail_count,
    output logic [N_IN-1:0]     first_fail_idx,
    output logic                first_fail_valid,
    output logic [nv(N_IN)-1:0] captured
);

    localparam int unsigned NV   = nv(N_IN);
    localparam int unsigned FC_W = N_IN + 1;
    // An illegal dwell is raised to the minimum rather than breaking the timer.
    localparam int unsigned DWELL_EFF = (DWELL < DWELL_MIN) ? DWELL_MIN : DWELL;

    state_t            state, state_d;
    logic [N_IN-1:0]   idx, idx_d;
    logic [N_IN-1:0]   stim_d;
    logic              busy_d, done_d, pass_d;
    logic [FC_W-1:0]   fail_count_d;
    logic [N_IN-1:0]   first_fail_idx_d;
    logic              first_fail_valid_d;
    logic [NV-1:0]     captured_d;
    logic              launch_c;
    logic              timer_load_c;
    logic              term_c;

    dwell_timer #(
        .DWELL (DWELL_EFF)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load_c),
        .en     (state == RUN),
        .term_c (term_c)
    );

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            idx              <= '0;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            captured         <= '0;
        end else begin
            state            <= state_d;
            idx              <= idx_d;
            stim             <= stim_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            fail_count       <= fail_count_d;
            first_fail_idx   <= first_fail_idx_d;
            first_fail_valid <= first_fail_valid_d;
            captured         <= captured_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d            = state;
        idx_d              = idx;
        stim_d             = stim;
        busy_d             = busy;
        done_d             = done;
        pass_d             = pass;
        fail_count_d       = fail_count;
        first_fail_idx_d   = first_fail_idx;
        first_fail_valid_d = first_fail_valid;
        captured_d         = captured;
        launch_c           = 1'b0;
        timer_load_c       = 1'b0;

        case (state)
            IDLE: begin
                launch_c = start && !abort;
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    stim_d  = '0;
                    pass_d  = 1'b0;
                end else if (term_c) begin
                    captured_d[idx] = d_in;
                    if (d_in != EXPECTED[idx]) begin
                        fail_count_d = fail_count + FC_W'(1);
                        if (!first_fail_valid) begin
                            first_fail_idx_d   = idx;
                            first_fail_valid_d = 1'b1;
                        end
                    end
                    if (idx == N_IN'(NV - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        stim_d  = '0;
                        pass_d  = (fail_count_d == '0);
                    end else begin
                        idx_d        = idx + N_IN'(1);
                        stim_d       = idx + N_IN'(1);
                        timer_load_c = 1'b1;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    stim_d  = '0;
                    pass_d  = 1'b0;
                end else begin
                    launch_c = start;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Fresh sweep: clear results and start vector 0
        if (launch_c) begin
            state_d            = RUN;
            idx_d              = '0;
            stim_d             = '0;
            busy_d             = 1'b1;
            done_d             = 1'b0;
            pass_d             = 1'b0;
            fail_count_d       = '0;
            first_fail_idx_d   = '0;
            first_fail_valid_d = 1'b0;
            captured_d         = '0;
            timer_load_c       = 1'b1;
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with the default parameters
// (3 inputs, dwell 20, expected table 8'hEA = (A&B)|C).
module tb_truth_table_sequencer;

    localparam int unsigned N_IN  = 3;
    localparam int unsigned NV    = 8;
    localparam int unsigned DWELL = 20;
    localparam int unsigned SWEEP = NV * DWELL;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic [N_IN-1:0] stim;
    logic            d_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   fail_count;
    logic [N_IN-1:0] first_fail_idx;
    logic            first_fail_valid;
    logic [NV-1:0]   captured;

    int   vectors;
    int   miscompares;
    int   mode;      // 0 good CUT, 1 stuck-at-0, 2 inverted
    logic glitch;
    logic good;

    truth_table_sequencer #(
        .N_IN     (N_IN),
        .DWELL    (DWELL),
        .EXPECTED (8'hEA)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .stim             (stim),
        .d_in             (d_in),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail_count       (fail_count),
        .first_fail_idx   (first_fail_idx),
        .first_fail_valid (first_fail_valid),
        .captured         (captured)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CUT model: D = (A & B) | C, with fault modes and a glitch overlay
    always_comb begin
        good = (stim[2] & stim[1]) | stim[0];
        d_in = good;
        case (mode)
            1:       d_in = 1'b0;
            2:       d_in = ~good;
            default: d_in = good;
        endcase
        d_in = d_in ^ glitch;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input int b, input int d, input int p,
                           input int fc, input int ffi, input int ffv, input int cap);
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_pass"}, 32'(pass), 32'(p));
        chk({tag, "_fail_count"}, 32'(fail_count), 32'(fc));
        chk({tag, "_first_idx"}, 32'(first_fail_idx), 32'(ffi));
        chk({tag, "_first_valid"}, 32'(first_fail_valid), 32'(ffv));
        chk({tag, "_captured"}, 32'(captured), 32'(cap));
    endtask

    // Start pulse sampled at edge 0, then run to edge 160. Glitch is raised
    // after edge g_on and dropped after edge g_off; a second start is offered
    // at edge restart_e+1 while running.
    task automatic sweep(input string tag, input int g_on, input int g_off, input int restart_e);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk({tag, "_launch_busy"}, 32'(busy), 32'd1);
        chk({tag, "_launch_done"}, 32'(done), 32'd0);
        chk({tag, "_launch_stim"}, 32'(stim), 32'd0);
        chk({tag, "_launch_fc"}, 32'(fail_count), 32'd0);
        chk({tag, "_launch_cap"}, 32'(captured), 32'd0);
        chk({tag, "_launch_ffv"}, 32'(first_fail_valid), 32'd0);
        for (int e = 1; e <= int'(SWEEP); e++) begin
            tick(1);
            if (e == g_on)          glitch = 1'b1;
            if (e == g_off)         glitch = 1'b0;
            if (e == restart_e)     start  = 1'b1;
            if (e == restart_e + 1) start  = 1'b0;
            if (e < int'(SWEEP) && (e % int'(DWELL)) == 0)
                chk({tag, "_step_stim"}, 32'(stim), 32'(e / int'(DWELL)));
            if (e == int'(SWEEP) - 1)
                chk({tag, "_done_early"}, 32'(done), 32'd0);
        end
        chk({tag, "_end_stim"}, 32'(stim), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode        = 0;
        glitch      = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;

        // Reset state
        tick(2);
        chk_res("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset_stim", 32'(stim), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Good CUT
        mode = 0;
        sweep("good", -1, -1, -1);
        chk_res("good", 0, 1, 1, 0, 0, 0, 32'hEA);

        // Stuck-at-0 CUT, started from DONE
        mode = 1;
        sweep("stuck0", -1, -1, -1);
        chk_res("stuck0", 0, 1, 0, 5, 1, 1, 32'h00);

        // Asynchronous reset mid-sweep
        mode  = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(75);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_stim", 32'(stim), 32'd3);
        chk("mid_captured", 32'(captured), 32'h02);
        rst_n = 1'b0;
        #2;
        chk_res("async_rst", 0, 0, 0, 0, 0, 0, 0);
        chk("async_rst_stim", 32'(stim), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_stim", 32'(stim), 32'd0);

        // Abort during vector 2 with an inverted CUT
        mode  = 2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(50);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk_res("abort", 0, 0, 0, 2, 0, 1, 32'h01);
        chk("abort_stim", 32'(stim), 32'd0);
        tick(20);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_cap", 32'(captured), 32'h01);
        mode = 0;
        sweep("after_abort", -1, -1, -1);
        chk_res("after_abort", 0, 1, 1, 0, 0, 0, 32'hEA);

        // Abort out of DONE, then start+abort together in IDLE
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk_res("done_abort", 0, 0, 0, 0, 0, 0, 32'hEA);
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        chk("both_busy", 32'(busy), 32'd0);
        tick(20);
        chk("both_idle_busy", 32'(busy), 32'd0);
        chk("both_idle_stim", 32'(stim), 32'd0);

        // Extra start while running is ignored
        sweep("restart", -1, -1, 30);
        chk_res("restart", 0, 1, 1, 0, 0, 0, 32'hEA);

        // Glitch on vector 3 that clears before the last dwell cycle
        sweep("glitch_a", 65, 79, -1);
        chk_res("glitch_a", 0, 1, 1, 0, 0, 0, 32'hEA);
        sweep("glitch_b", 65, 79, -1);
        chk_res("glitch_b", 0, 1, 1, 0, 0, 0, 32'hEA);

        // Glitch only on the last dwell cycle of vector 5 is captured
        sweep("late_glitch", 119, 120, -1);
        chk_res("late_glitch", 0, 1, 0, 1, 5, 1, 32'hCA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
